game_sequencer: RTL and testbench

Top-level game controller for Breakout. Sequences each match through idle, serve, play, life-lost and end states. Tracks remaining lives and remaining blocks, and gates the ball and bar movers through registered enable/park controls. Sits between the `vga` frame timing, the `move_ball`/`move_bar` movers, the block instances and `placar`.

---
 rtl/game_sequencer_if.sv | 30 +++
 rtl/game_sequencer.sv | 155 +++++++++++++++
 tb/tb_game_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Bundle of control inputs and status outputs exchanged between the Breakout
// game sequencer and the rest of the game (frame timing, movers, blocks, score).
interface game_sequencer_if;
  logic       start;
  logic       frame_tick;
  logic       hit_block;
  logic       ball_lost;
  logic       ball_enable;
  logic       ball_park;
  logic       bar_enable;
  logic [1:0] lives;
  logic [4:0] blocks_left;
  logic [2:0] state;
  logic       game_over;
  logic       game_won;

  // Game environment side: drives events, observes sequencer status
  modport master (
    output start, frame_tick, hit_block, ball_lost,
    input  ball_enable, ball_park, bar_enable, lives, blocks_left,
           state, game_over, game_won
  );

  // Sequencer side
  modport slave (
    input  start, frame_tick, hit_block, ball_lost,
    output ball_enable, ball_park, bar_enable, lives, blocks_left,
           state, game_over, game_won
  );
endinterface

// File: rtl/game_sequencer.sv
// Breakout match controller: walks each match through idle, serve, play,
// life-lost and end states, tracks lives and remaining blocks, and gates the
// ball/bar movers with registered enable and park controls.
module game_sequencer #(
  parameter int LIVES        = 3,
  parameter int N_BLOCKS     = 15,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90
) (
  input  logic            clock,
  input  logic            reset,
  game_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] MISS  = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;
  localparam logic [2:0] WIN   = 3'd5;

  localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
  localparam logic [4:0] BLOCKS_INIT = 5'(N_BLOCKS);
  localparam logic [7:0] SERVE_LAST  = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MISS_LAST   = 8'(MISS_FRAMES - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [4:0] blocks_q, blocks_d;
  logic [7:0] frame_q, frame_d;
  logic       start_q, start_d;
  logic       ball_enable_q, ball_enable_d;
  logic       ball_park_q, ball_park_d;
  logic       bar_enable_q, bar_enable_d;
  logic       game_over_q, game_over_d;
  logic       game_won_q, game_won_d;

  logic       start_rise;
  logic       wall_empty;

  assign start_rise = bus.start & ~start_q;

  // Next-state, counter and score updates for the match sequence
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d    = state_q;
    lives_d    = lives_q;
    blocks_d   = blocks_q;
    frame_d    = frame_q;
    start_d    = bus.start;
    wall_empty = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d  = SERVE;
          lives_d  = LIVES_INIT;
          blocks_d = BLOCKS_INIT;
        end
      end
      SERVE: begin
        if (!bus.start) begin
          state_d = IDLE;
        end else if (bus.frame_tick) begin
          if (frame_q == SERVE_LAST) state_d = PLAY;
          else if (frame_q != 8'hFF) frame_d = frame_q + 8'd1;
        end
      end
      PLAY: begin
        if (!bus.start) begin
          state_d = IDLE;
        end else begin
          // A block hit always counts, even when the ball is lost in the same cycle
          if (bus.hit_block && blocks_q != 5'd0) begin
            blocks_d   = blocks_q - 5'd1;
            wall_empty = (blocks_q == 5'd1);
          end
          if (wall_empty) begin
            state_d = WIN;
          end else if (bus.ball_lost) begin
            if (lives_q > 2'd1) begin
              lives_d = lives_q - 2'd1;
              state_d = MISS;
            end else begin
              lives_d = 2'd0;
              state_d = OVER;
            end
          end
        end
      end
      MISS: begin
        if (!bus.start) begin
          state_d = IDLE;
        end else if (bus.frame_tick) begin
          if (frame_q == MISS_LAST) state_d = SERVE;
          else if (frame_q != 8'hFF) frame_d = frame_q + 8'd1;
        end
      end
      OVER, WIN: begin
        if (!bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The frame counter restarts on every state entry
    if (state_d != state_q) frame_d = 8'd0;

    // Outputs decode from the next state so they register alongside it
    ball_enable_d = (state_d == PLAY);
    ball_park_d   = (state_d != PLAY);
    bar_enable_d  = (state_d == SERVE) || (state_d == PLAY);
    game_over_d   = (state_d == OVER);
    game_won_d    = (state_d == WIN);
  end

  // Synchronous state and output registers
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (reset) begin
      state_q       <= IDLE;
      lives_q       <= LIVES_INIT;
      blocks_q      <= BLOCKS_INIT;
      frame_q       <= 8'd0;
      start_q       <= 1'b1;
      ball_enable_q <= 1'b0;
      ball_park_q   <= 1'b1;
      bar_enable_q  <= 1'b0;
      game_over_q   <= 1'b0;
      game_won_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      blocks_q      <= blocks_d;
      frame_q       <= frame_d;
      start_q       <= start_d;
      ball_enable_q <= ball_enable_d;
      ball_park_q   <= ball_park_d;
      bar_enable_q  <= bar_enable_d;
      game_over_q   <= game_over_d;
      game_won_q    <= game_won_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.lives       = lives_q;
  assign bus.blocks_left = blocks_q;
  assign bus.ball_enable = ball_enable_q;
  assign bus.ball_park   = ball_park_q;
  assign bus.bar_enable  = bar_enable_q;
  assign bus.game_over   = game_over_q;
  assign bus.game_won    = game_won_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: directed match scenarios followed by random
// play, each cycle's expected outputs queued by a behavioural match model and
// compared by an independent monitor process.
module tb_game_sequencer;

  localparam int LIVES        = 3;
  localparam int N_BLOCKS     = 2;
  localparam int SERVE_FRAMES = 2;
  localparam int MISS_FRAMES  = 2;

  typedef enum int {M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_MISS = 3, M_OVER = 4, M_WIN = 5} mstate_e;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] lives;
    logic [4:0] blocks;
    logic       ball_en;
    logic       park;
    logic       bar_en;
    logic       over;
    logic       won;
  } obs_t;

  logic clock;
  logic reset;
  game_sequencer_if bus ();

  game_sequencer #(
    .LIVES       (LIVES),
    .N_BLOCKS    (N_BLOCKS),
    .SERVE_FRAMES(SERVE_FRAMES),
    .MISS_FRAMES (MISS_FRAMES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   started  = 0;
  obs_t exp_q[$];

  // Behavioural model: match status in plain integers
  mstate_e m_state  = M_IDLE;
  int      m_lives  = LIVES;
  int      m_blocks = N_BLOCKS;
  int      m_frames = 0;
  bit      m_prev   = 1'b1;

  task automatic model_step(input bit rst, input bit st, input bit tk, input bit hit, input bit lost);
    mstate_e old;
    bit      rise;
    if (rst) begin
      m_state = M_IDLE; m_lives = LIVES; m_blocks = N_BLOCKS; m_frames = 0; m_prev = 1'b1;
      return;
    end
    rise   = st && !m_prev;
    m_prev = st;
    old    = m_state;
    case (m_state)
      M_IDLE: if (rise) begin m_state = M_SERVE; m_lives = LIVES; m_blocks = N_BLOCKS; end
      M_SERVE: begin
        if (!st) m_state = M_IDLE;
        else if (tk) begin
          m_frames++;
          if (m_frames == SERVE_FRAMES) m_state = M_PLAY;
        end
      end
      M_PLAY: begin
        if (!st) m_state = M_IDLE;
        else begin
          bit won;
          won = 0;
          if (hit && m_blocks > 0) begin
            m_blocks--;
            won = (m_blocks == 0);
          end
          if (won) m_state = M_WIN;
          else if (lost) begin
            m_lives--;
            m_state = (m_lives == 0) ? M_OVER : M_MISS;
          end
        end
      end
      M_MISS: begin
        if (!st) m_state = M_IDLE;
        else if (tk) begin
          m_frames++;
          if (m_frames == MISS_FRAMES) m_state = M_SERVE;
        end
      end
      default: if (!st) m_state = M_IDLE;
    endcase
    if (m_state != old) m_frames = 0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.state   = 3'(int'(m_state));
    o.lives   = 2'(m_lives);
    o.blocks  = 5'(m_blocks);
    o.ball_en = (m_state == M_PLAY);
    o.park    = (m_state != M_PLAY);
    o.bar_en  = (m_state == M_SERVE) || (m_state == M_PLAY);
    o.over    = (m_state == M_OVER);
    o.won     = (m_state == M_WIN);
    return o;
  endfunction

  // Drive one cycle of stimulus and queue the response expected after the edge
  task automatic cycle(input bit rst, input bit st, input bit tk, input bit hit, input bit lost);
    @(negedge clock);
    reset          = rst;
    bus.start      = st;
    bus.frame_tick = tk;
    bus.hit_block  = hit;
    bus.ball_lost  = lost;
    model_step(rst, st, tk, hit, lost);
    exp_q.push_back(model_obs());
    started = 1;
  endtask

  task automatic run(input int n, input bit st);
    for (int i = 0; i < n; i++) cycle(0, st, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 0, 0, 0);
    end
  endtask

  // Monitor: compare DUT status against the queued expectation each cycle
  initial begin
    obs_t got, exp;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (started) begin
        got = '{bus.state, bus.lives, bus.blocks_left, bus.ball_enable,
                bus.ball_park, bus.bar_enable, bus.game_over, bus.game_won};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow cyc=%0d: no expected entry for observed state=%0d", cyc, got.state);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL status cyc=%0d got st=%0d lv=%0d bl=%0d be=%b pk=%b bre=%b go=%b gw=%b want st=%0d lv=%0d bl=%0d be=%b pk=%b bre=%b go=%b gw=%b",
                     cyc, got.state, got.lives, got.blocks, got.ball_en, got.park, got.bar_en, got.over, got.won,
                     exp.state, exp.lives, exp.blocks, exp.ball_en, exp.park, exp.bar_en, exp.over, exp.won);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.frame_tick = 1'b0; bus.hit_block = 1'b0; bus.ball_lost = 1'b0;

    // Reset, then idle with start low
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    run(100, 0);

    // Start a match, serve for two ticks, into PLAY
    run(3, 1);
    ticks(SERVE_FRAMES);
    run(2, 1);

    // Lose all three lives, then drop start
    for (int k = 0; k < LIVES; k++) begin
      cycle(0, 1, 0, 0, 1);
      run(1, 1);
      ticks(MISS_FRAMES);
      ticks(SERVE_FRAMES);
    end
    run(3, 1);
    run(3, 0);

    // Win by clearing the wall; extra hits leave it empty
    run(1, 1);
    ticks(SERVE_FRAMES);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    run(2, 1);
    run(2, 0);

    // Last block and last life lost in the same cycle: the win takes it
    run(1, 1);
    ticks(SERVE_FRAMES);
    cycle(0, 1, 0, 1, 0);
    for (int k = 0; k < LIVES - 1; k++) begin
      cycle(0, 1, 0, 0, 1);
      ticks(MISS_FRAMES);
      ticks(SERVE_FRAMES);
    end
    cycle(0, 1, 0, 1, 1);
    run(2, 1);
    run(2, 0);

    // Abort during SERVE with a coinciding tick
    run(1, 1);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    run(2, 0);

    // Reset in the middle of PLAY
    run(1, 1);
    ticks(SERVE_FRAMES);
    cycle(1, 1, 1, 1, 1);
    run(3, 1);
    run(2, 0);

    // Random play
    begin
      bit st;
      st = 0;
      for (int i = 0; i < 4000; i++) begin
        if (st) st = ($urandom_range(0, 59) != 0);
        else    st = ($urandom_range(0, 3) == 0);
        cycle(($urandom_range(0, 499) == 0), st,
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 9) == 0));
      end
    end

    @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
